// File: rtl/mem_copy_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_copy_dma_pkg
// Description : Shared types and constants for the mem_copy_dma block:
//               FSM state encoding, default widths and index directions.
//               MEM_COPY_DMA_BACKWARD_EN (optional) enables descending copies
//               for overlapping dst>src regions.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_copy_dma_pkg;

  localparam int c_DEF_ADDR_W = 32;
  localparam int c_DEF_DATA_W = 32;
  localparam int c_DEF_LEN_W  = 16;

  // Index walk direction
  localparam logic c_DIR_UP = 1'b0;
  localparam logic c_DIR_DN = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_copy_dma_idx.sv
`default_nettype none
// ============================================================================
// Module      : mem_copy_dma_idx
// Description : Loadable word-index counter for the copy engine. Steps up or
//               down by one and flags the terminal count (i_term when
//               counting up, zero when counting down).
// Ports       : clk, rst       - clock, async active-high reset
//               i_load/_val    - load a start index
//               i_step         - advance one word in direction i_dir
//               i_term         - last index of an ascending walk
//               o_idx, o_tc    - current index, terminal-count flag
// Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_dma_idx
  import mem_copy_dma_pkg::*;
#(
  parameter int LEN_W = c_DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [LEN_W-1:0] i_load_val,
  input  logic             i_step,
  input  logic             i_dir,
  input  logic [LEN_W-1:0] i_term,
  output logic [LEN_W-1:0] o_idx,
  output logic             o_tc
);

  localparam logic [LEN_W-1:0] c_ONE = LEN_W'(1);

  logic [LEN_W-1:0] r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (i_load) begin
      r_idx <= i_load_val;
    end else if (i_step) begin
      r_idx <= (i_dir == c_DIR_UP) ? r_idx + c_ONE : r_idx - c_ONE;
    end
  end

  assign o_idx = r_idx;
  assign o_tc  = (i_dir == c_DIR_UP) ? (r_idx == i_term) : (r_idx == '0);

endmodule
`default_nettype wire

// File: rtl/mem_copy_dma.sv
`default_nettype none
// ============================================================================
// Module      : mem_copy_dma
// Description : Block-copy initiator on the single-port data memory. Copies
//               len words from src_addr to dst_addr, one read cycle and one
//               write cycle per word, then pulses done. Addresses wrap
//               modulo 2^ADDR_W. Memory strobes decode from state only.
//               Optional macro MEM_COPY_DMA_BACKWARD_EN: overlapping copies
//               with dst>src run descending (memmove semantics).
// Ports       : clk, rst                  - clock, async active-high reset
//               start/src_addr/dst_addr/len - copy request (IDLE only)
//               busy, done                  - status (done = 1-cycle pulse)
//               MemRead/MemWrite/Address/WriteData/ReadData - memory port
// Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_dma
  import mem_copy_dma_pkg::*;
#(
  parameter int ADDR_W = c_DEF_ADDR_W,
  parameter int DATA_W = c_DEF_DATA_W,
  parameter int LEN_W  = c_DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] ReadData
);

  localparam logic [LEN_W-1:0] c_ONE = LEN_W'(1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic [DATA_W-1:0] r_buf;

  logic              w_accept;
  logic              w_dir;
  logic              w_dir_new;
  logic              w_step;
  logic              w_tc;
  logic [LEN_W-1:0]  w_idx;
  logic [LEN_W-1:0]  w_load_val;
  logic [LEN_W-1:0]  w_term;
  logic [ADDR_W-1:0] w_idx_ext;

  assign w_accept = (r_state == IDLE) && start;

`ifdef MEM_COPY_DMA_BACKWARD_EN
  // Overlap test done one bit wider so src+len cannot wrap and hide overlap.
  logic [ADDR_W:0] w_src_x;
  logic [ADDR_W:0] w_dst_x;
  logic [ADDR_W:0] w_src_end;
  logic            r_dir;

  assign w_src_x   = {1'b0, src_addr};
  assign w_dst_x   = {1'b0, dst_addr};
  assign w_src_end = w_src_x + (ADDR_W+1)'(len);
  assign w_dir_new = ((w_dst_x > w_src_x) && (w_dst_x < w_src_end)) ? c_DIR_DN : c_DIR_UP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dir <= c_DIR_UP;
    end else if (w_accept) begin
      r_dir <= w_dir_new;
    end
  end

  assign w_dir = r_dir;
`else
  assign w_dir_new = c_DIR_UP;
  assign w_dir     = c_DIR_UP;
`endif

  // Descending walks start from the last word.
  assign w_load_val = (w_dir_new == c_DIR_DN) ? len - c_ONE : '0;
  assign w_term     = r_len - c_ONE;
  assign w_step     = (r_state == WR) && !w_tc;
  assign w_idx_ext  = ADDR_W'(w_idx);

  mem_copy_dma_idx #(
    .LEN_W (LEN_W)
  ) u_idx (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (w_load_val),
    .i_step     (w_step),
    .i_dir      (w_dir),
    .i_term     (w_term),
    .o_idx      (w_idx),
    .o_tc       (w_tc)
  );

  // Request latches and read-data buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src <= '0;
      r_dst <= '0;
      r_len <= '0;
      r_buf <= '0;
    end else begin
      if (w_accept) begin
        r_src <= src_addr;
        r_dst <= dst_addr;
        r_len <= len;
      end
      if (r_state == RD) begin
        r_buf <= ReadData;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = '0;
    WriteData = '0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (len == '0) ? FIN : RD;
        end
      end
      RD: begin
        busy    = 1'b1;
        MemRead = 1'b1;
        Address = r_src + w_idx_ext;
        w_next  = WR;
      end
      WR: begin
        busy      = 1'b1;
        MemWrite  = 1'b1;
        Address   = r_dst + w_idx_ext;
        WriteData = r_buf;
        w_next    = w_tc ? FIN : RD;
      end
      FIN: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/mem_copy_dma.md
Name: mem_copy_dma

Overview:
- Memory-side initiator that drives the single-port data memory interface (MemRead/MemWrite/Address/WriteData in, ReadData back) to copy a block of words from a source region to a destination region.
- Sits beside the processor datapath and owns the memory port while busy; the top level muxes its memory signals against the CPU's using busy as select.
- Memory read data is combinational, same cycle; memory write commits on posedge clk.

Parameters:
- ADDR_W, 32, width of Address, src_addr and dst_addr.
- DATA_W, 32, width of WriteData and ReadData.
- LEN_W, 16, width of the word count len.

Ports:
- clk  input  1  single clock, all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a copy; sampled only in IDLE.
- src_addr  input  ADDR_W  first source word address; latched on accepted start.
- dst_addr  input  ADDR_W  first destination word address; latched on accepted start.
- len  input  LEN_W  number of words; latched on accepted start.
- busy  output  1  high in RD and WR states.
- done  output  1  one-cycle pulse when a copy completes.
- MemRead  output  1  read strobe to memory.
- MemWrite  output  1  write strobe to memory.
- Address  output  ADDR_W  memory word address.
- WriteData  output  DATA_W  memory write data.
- ReadData  input  DATA_W  combinational memory read data.

Behaviour:
- States: IDLE, RD, WR, FIN. Reset value: IDLE. All outputs are 0 in IDLE, and all internal registers (src/dst/len latches, index, data buffer) reset to 0.
- IDLE: start=1 at an edge latches src_addr, dst_addr and len, and clears index i.
  - If len==0, next state is FIN and no memory access occurs.
  - Otherwise next state is RD.
- RD: MemRead=1, MemWrite=0, Address=src+i. At the edge, buf<=ReadData and the FSM goes to WR.
- WR: MemWrite=1, MemRead=0, Address=dst+i, WriteData=buf. At the edge:
  - If i==len-1, go to FIN.
  - Otherwise i<=i+1 and go to RD.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- Latency: for len=N>0, done is asserted 2N+1 cycles after the accepting edge. For len=0, done is asserted 1 cycle after it.
- All memory outputs decode from the state registers only; none are driven combinationally from inputs.
- Address arithmetic is modulo 2^ADDR_W. src+i and dst+i wrap silently past the top of the address space.
- start while busy or in FIN is ignored, with no queuing. Input changes after acceptance have no effect.
- Overlapping regions are copied in ascending order. When dst>src and the regions overlap, the result is the defined forward-smear.
- Async reset mid-copy forces IDLE at once. MemWrite drops before the next edge, so no partial write is issued at that edge, and no done is pulsed.
- Address=0 and WriteData=0 whenever the corresponding strobe is low.

Optional Feature:
- Macro: MEM_COPY_DMA_BACKWARD_EN.
- When defined:
  - On acceptance, if dst>src and dst<src+len (computed in ADDR_W+1 bits), the copy runs descending: i goes from len-1 down to 0.
  - Overlapping copies then behave like memmove.
  - Cycle count is unchanged.
- When undefined: always ascending, as described above.

Decomposition:
- Package mem_copy_dma_pkg holds:
  - the state enum typedef (IDLE, RD, WR, FIN);
  - default width localparams;
  - the direction constant used by the optional feature.
- One natural sub-module, mem_copy_dma_idx: a loadable index counter with an increment/decrement control and a terminal-count flag, driven by the FSM.
- Data buffer and address latches are plain registers inside the top.

Test Plan:
- Preload mem[100..103]={A,B,C,D}; start with src=100, dst=200, len=4. Expect mem[200..203]={A,B,C,D}, done exactly 9 cycles after the accepting edge, and busy high for 8 cycles.
- len=0 with src=5, dst=6. Expect done 1 cycle after acceptance, MemRead and MemWrite never asserted, and memory unchanged.
- Wrap: src=2^32-2, dst=10, len=3. Expect reads at 0xFFFFFFFE, 0xFFFFFFFF and 0x0, with those words landing in mem[10..12].
- Pulse start again during a busy copy with different src, dst and len. Expect it to be ignored, the original copy to complete unchanged, and exactly one done pulse.
- Assert rst during the second WR of a len=4 copy. Expect outputs 0 immediately, that destination word not written, no done pulse, and a new start afterwards to work normally.
- Overlap src=50, dst=51, len=3 with mem[50..52]={1,2,3}:
  - without the macro, expect mem[51..53]={1,1,1};
  - with MEM_COPY_DMA_BACKWARD_EN, expect {1,2,3}.
